urand_pair_src: RTL
===================

Name: urand_pair_src

Overview:
- Stimulus-side source for the randist Box-Muller block.
- Generates pairs of uniform IEEE-754 doubles U1, U2 in (0,1) from a xorshift64 PRNG and drives them into randist with a single-cycle pushin strobe.
- Counts randist pushout strobes to cap the number of pairs in flight, because randist has no backpressure.
- Sits between the configuration/control logic and randist in the hardware random-normal generator path.

Parameters:
- MAX_INFLIGHT, 512: maximum pairs pushed but not yet returned via pushout (1..1023).
- GAP, 0: idle cycles inserted after each pushin (0..15).
- DEFAULT_SEED, 64'h9E3779B97F4A7C15: PRNG state used after reset and when seed==0 is loaded.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; asynchronous, active-high.
- seed_load  in  1  load seed into the PRNG state; honoured only in IDLE.
- seed  in  64  seed value.
- start  in  1  begin a run of n_pairs; honoured only in IDLE.
- n_pairs  in  16  number of pairs to push; sampled with start.
- pushout_rtn  in  1  randist pushout, used to return one in-flight credit.
- pushin  out  1  valid strobe to randist.
- U1  out  64  double U1 to randist.
- U2  out  64  double U2 to randist.
- busy  out  1  high from start acceptance until the done cycle.
- done  out  1  one-cycle pulse when the last pair of a run has been pushed.
- inflight  out  11  current outstanding pair count.
- err  out  1  sticky flag: pushout_rtn received while inflight==0.

Behaviour:
- Reset values: pushin=0, U1=0, U2=0, busy=0, done=0, inflight=0, err=0, state=IDLE, PRNG x=DEFAULT_SEED.
- All outputs are registered and change only at a clk edge, so they hold stable after the edge.
- PRNG step: x^=x<<13; x^=x>>7; x^=x<<17.
- Each generate step converts the current x, then advances x by one PRNG step.
- Conversion (u52_to_f64):
  - m = x[51:0]; if m==0, force m=1.
  - Value is m*2^-52, exact and normalised.
  - p = index of the leading one of m.
  - Exponent field = 1023-52+p.
  - Mantissa = (m<<(52-p))[51:0].
  - Sign = 0.
  - Result range is [2^-52, 1-2^-52]; 0.0 is never produced.
- FSM states and transitions:
  - IDLE:
    - seed_load sets x = (seed==0) ? DEFAULT_SEED : seed.
    - If start and seed_load are both high, seed_load takes effect first; the run then begins from the new seed.
    - start with n_pairs==0: done=1 for one cycle, busy stays 0, no push.
    - start with n_pairs>0: rem=n_pairs, busy=1, go to GEN1.
  - GEN1: U1<=conv(x), advance x, go to GEN2.
  - GEN2:
    - If inflight (after this cycle's return) < MAX_INFLIGHT: U2<=conv(x), advance x, pushin<=1, rem--, go to GAPW.
    - Otherwise stall in GEN2 with pushin=0; x does not advance.
  - GAPW:
    - pushin<=0.
    - Wait GAP further cycles.
    - Then, if rem==0: done=1 for one cycle, busy=0, go to IDLE. Otherwise go to GEN1.
- pushin is high for exactly one cycle per pair.
- U1 and U2 hold their values until the next GEN1 edge, which is at least one cycle after pushin falls.
- Start-to-first-push latency: start sampled at edge 0 → U1 at edge 1 → U2 and pushin=1 at edge 2.
- Push throughput: one pair per 3+GAP cycles when not credit-stalled.
- inflight accounting:
  - +1 on each pushin issue, -1 on each pushout_rtn.
  - A simultaneous issue and return leaves inflight unchanged.
  - A return while inflight==0 sets err and leaves inflight at 0.
- done fires when the last push completes; it does not wait for the returns to drain. The drained condition is busy==0 && inflight==0.
- start or seed_load while busy: ignored.
- rst asserted mid-run: everything returns to reset values immediately, and any in-flight count is discarded.

Decomposition:
- Shared package urand_pkg:
  - DEFAULT_SEED
  - F64_BIAS=1023
  - MANT_W=52
  - FSM state enum {IDLE, GEN1, GEN2, GAPW}
  - xorshift64 step function
- Sub-module u52_to_f64: combinational 52-bit leading-one detect plus normalising shift. It is the natural unit to test exhaustively for each leading-one position.

Test Plan:
- Reset, seed_load seed=1, start n_pairs=1, GAP=0:
  - U1 = 64'h3CB0000000000000 and U2 = 64'h3E90208810400000 at pushin.
  - pushin is high 2 edges after start.
  - done pulses on the edge after the push.
- seed_load seed=0, then start:
  - First U1 = conv(DEFAULT_SEED).
  - No value equal to 0.0 or ≥1.0 appears over 10000 pairs; check via $bitstoreal.
- MAX_INFLIGHT=4, start n_pairs=10, no pushout_rtn:
  - Exactly 4 pushins, then a GEN2 stall with inflight=4 and busy=1.
  - One pushout_rtn → the 5th pushin follows 1 cycle later.
- Return in the same cycle as a pushin issue: inflight stays constant.
- Extra pushout_rtn at inflight=0: err=1 and remains 1 until rst.
- Feed pairs into a randist instance, n_pairs=1000, GAP=3:
  - Pushes are spaced 6 cycles apart.
  - Z matches the real-math Box-Muller model within 1e-8.
  - inflight returns to 0.
- rst pulse mid-run (after 3 pushes): all outputs reset asynchronously, no further pushins, and a fresh start works normally.
- start while busy: ignored.

Source files
------------

// File: rtl/urand_pkg.sv
// urand_pkg: shared constants, FSM states and xorshift64 step for the uniform pair source
package urand_pkg;
    localparam logic [63:0] DEFAULT_SEED = 64'h9E3779B97F4A7C15;
    localparam int F64_BIAS = 1023;
    localparam int MANT_W = 52;
    typedef enum logic [1:0] {IDLE, GEN1, GEN2, GAPW} state_t;
    function automatic logic [63:0] xs64_step(input logic [63:0] v);
        logic [63:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction
endpackage

// File: rtl/u52_to_f64.sv
// u52_to_f64: maps a 52-bit fraction to the exact normalised double m*2^-52 (m==0 treated as 1)
module u52_to_f64 import urand_pkg::*; (
    input  logic [MANT_W-1:0] m_in,
    output logic [63:0]       f
);
    logic [MANT_W-1:0] m;
    logic [MANT_W-1:0] sh;
    logic [5:0]        p;
    logic [10:0]       e;
    always_comb begin
        m = (m_in == '0) ? {{(MANT_W-1){1'b0}}, 1'b1} : m_in;
        p = '0;
        for (int i = 0; i < MANT_W; i++) p = m[i] ? 6'(i) : p;
        sh = m << (6'(MANT_W) - p);
        e = 11'(F64_BIAS - MANT_W) + {5'b0, p};
        f = {1'b0, e, sh};
    end
endmodule

// File: rtl/urand_pair_src.sv
// urand_pair_src: credit-limited source of uniform double pairs for the Box-Muller block
module urand_pair_src import urand_pkg::*; #(
    parameter int          MAX_INFLIGHT = 512,
    parameter int          GAP          = 0,
    parameter logic [63:0] DEFAULT_SEED = urand_pkg::DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [63:0] seed,
    input  logic        start,
    input  logic [15:0] n_pairs,
    input  logic        pushout_rtn,
    output logic        pushin,
    output logic [63:0] U1,
    output logic [63:0] U2,
    output logic        busy,
    output logic        done,
    output logic [10:0] inflight,
    output logic        err
);
    localparam logic [10:0] MAX_W = 11'(MAX_INFLIGHT);
    localparam logic [3:0]  GAP_W = 4'(GAP);
    state_t      state, state_n;
    logic [63:0] x, x_n, u1_n, u2_n, cf;
    logic [15:0] rem, rem_n;
    logic [3:0]  gcnt, gcnt_n;
    logic [10:0] inflight_n, infl_ret;
    logic        pushin_n, busy_n, done_n, err_n, ret, go;

    u52_to_f64 u_conv (.m_in(x[MANT_W-1:0]), .f(cf));

    always_comb begin
        state_n  = state;
        x_n      = x;
        rem_n    = rem;
        gcnt_n   = gcnt;
        u1_n     = U1;
        u2_n     = U2;
        pushin_n = 1'b0;
        busy_n   = busy;
        done_n   = 1'b0;
        go       = 1'b0;
        ret      = pushout_rtn && inflight != '0;
        infl_ret = inflight - 11'(ret);
        err_n    = err | (pushout_rtn && inflight == '0);
        case (state)
            IDLE: begin
                if (seed_load) x_n = (seed == '0) ? DEFAULT_SEED : seed;
                if (start) begin
                    done_n  = n_pairs == '0;
                    busy_n  = n_pairs != '0;
                    rem_n   = n_pairs;
                    state_n = (n_pairs == '0) ? IDLE : GEN1;
                end
            end
            GEN1: begin
                u1_n    = cf;
                x_n     = xs64_step(x);
                state_n = GEN2;
            end
            GEN2: if (infl_ret < MAX_W) begin
                go       = 1'b1;
                u2_n     = cf;
                x_n      = xs64_step(x);
                pushin_n = 1'b1;
                rem_n    = rem - 16'd1;
                gcnt_n   = '0;
                state_n  = GAPW;
            end
            GAPW: if (gcnt == GAP_W) begin
                done_n  = rem == '0;
                busy_n  = rem != '0;
                state_n = (rem == '0) ? IDLE : GEN1;
            end else gcnt_n = gcnt + 4'd1;
            default: state_n = IDLE;
        endcase
        inflight_n = infl_ret + 11'(go);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            x        <= DEFAULT_SEED;
            rem      <= '0;
            gcnt     <= '0;
            U1       <= '0;
            U2       <= '0;
            pushin   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            x        <= x_n;
            rem      <= rem_n;
            gcnt     <= gcnt_n;
            U1       <= u1_n;
            U2       <= u2_n;
            pushin   <= pushin_n;
            busy     <= busy_n;
            done     <= done_n;
            inflight <= inflight_n;
            err      <= err_n;
        end
    end
endmodule
